// File: rtl/matmul_result_unit_pkg.sv
// Shared definitions for the matmul result unit.
// - Default parameter values and derived-width helper.
// - FSM state encoding for the capture / bias-add / write sequence.
// - flat_idx(): maps matrix coordinate (r,c) to its flat element index.
//   Element bit offset in c_matrix_i is flat_idx(r,c,MAX_DIM) * element width.
package matmul_result_unit_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_BUS_WIDTH   = 16;
    localparam int DEF_SP_NTARGETS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // clog2 that never returns 0, so 1-entry configurations still get a 1-bit field
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Column-major flattening used by the systolic array output bus
    function automatic int flat_idx(input int r, input int c, input int max_dim);
        return c * max_dim + r;
    endfunction

endpackage

// File: rtl/matmul_result_unit_sp.sv
// Scratchpad of result matrices: NT entries x NUM_EL elements of EL_W bits.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (clears all entries)
//   we/waddr/wdata      full-entry write, element e at wdata[e*EL_W +: EL_W]
//   baddr/bidx/bdata    combinational element read (bias operand)
//   rd_en/raddr/ridx    registered element read (bus side)
//   rd_data/rd_valid    read result one cycle after rd_en; rd_data holds otherwise
// A registered read and a write to the same entry in one cycle return the old
// content, since both sample the array at the same edge.
module matmul_result_sp
    import matmul_result_unit_pkg::*;
#(
    parameter int EL_W   = 16,
    parameter int NUM_EL = 4,
    parameter int NT     = 4,
    parameter int AW     = 2,
    parameter int IW     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [NUM_EL*EL_W-1:0]  wdata,
    input  logic [AW-1:0]           baddr,
    input  logic [IW-1:0]           bidx,
    output logic [EL_W-1:0]         bdata,
    input  logic                    rd_en,
    input  logic [AW-1:0]           raddr,
    input  logic [IW-1:0]           ridx,
    output logic [EL_W-1:0]         rd_data,
    output logic                    rd_valid
);

    logic [EL_W-1:0] mem [NT][NUM_EL];
    logic            rd_in_range;

    always_comb begin
        bdata = mem[baddr][bidx];
    end

    // Out-of-range element (or entry) reads complete normally but return zero
    always_comb begin
        rd_in_range = ({1'b0, ridx} < (IW+1)'(NUM_EL)) && ({1'b0, raddr} < (AW+1)'(NT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int t = 0; t < NT; t++) begin
                for (int e = 0; e < NUM_EL; e++) begin
                    mem[t][e] <= '0;
                end
            end
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (we) begin
                for (int e = 0; e < NUM_EL; e++) begin
                    mem[waddr][e] <= wdata[e*EL_W +: EL_W];
                end
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_in_range ? mem[raddr][ridx] : '0;
            end
        end
    end

endmodule

// File: rtl/matmul_result_unit.sv
// Result stage behind the systolic matmul array.
// On a rising edge of finish_mul_i the flat result matrix and PE overflow flags
// are captured, optionally summed element-wise with a stored scratchpad entry
// (one element per cycle), then written as a whole into the destination entry.
// Optional build macro: MATMUL_RESULT_SAT_EN -- bias-add overflow saturates
// instead of wrapping (the overflow flag is set either way).
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   c_matrix_i, flags_i      flat result / per-PE overflow, element (r,c) at flat_idx(r,c)
//   finish_mul_i             completion level; its rising edge starts an op
//   mode_bias_i, src_sp_i    bias enable and bias source entry (sampled at capture)
//   dst_sp_i                 destination entry (sampled at capture)
//   rd_en_i, rd_addr_i       bus read request, address = {entry, element index}
//   rd_data_o, rd_valid_o    registered read response
//   flags_o                  flags of the last completed op
//   busy_o, done_o           op in progress / one-cycle completion pulse
//   overrun_o                sticky: completion edge seen while busy
module matmul_result_unit
    import matmul_result_unit_pkg::*;
#(
    parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int  BUS_WIDTH   = DEF_BUS_WIDTH,
    parameter int  SP_NTARGETS = DEF_SP_NTARGETS,
    localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
    localparam int NUM_EL      = MAX_DIM * MAX_DIM,
    localparam int EL_W        = 2 * DATA_WIDTH,
    localparam int SP_AW       = clog2_min1(SP_NTARGETS),
    localparam int IDX_W       = clog2_min1(NUM_EL)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_EL*EL_W-1:0]   c_matrix_i,
    input  logic [NUM_EL-1:0]        flags_i,
    input  logic                     finish_mul_i,
    input  logic                     mode_bias_i,
    input  logic [SP_AW-1:0]         src_sp_i,
    input  logic [SP_AW-1:0]         dst_sp_i,
    input  logic                     rd_en_i,
    input  logic [SP_AW+IDX_W-1:0]   rd_addr_i,
    output logic [EL_W-1:0]          rd_data_o,
    output logic                     rd_valid_o,
    output logic [NUM_EL-1:0]        flags_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overrun_o
);

    state_e                   state;
    logic                     fin_prev;
    logic                     edge_q;
    logic [NUM_EL*EL_W-1:0]   cap_c;
    logic [NUM_EL-1:0]        cap_flags;
    logic [SP_AW-1:0]         src_q;
    logic [SP_AW-1:0]         dst_q;
    logic [IDX_W-1:0]         idx;

    logic [EL_W-1:0]          bias_el;
    logic [EL_W-1:0]          cur_el;
    logic [EL_W-1:0]          sum;
    logic [EL_W-1:0]          sum_fix;
    logic                     ovf;
    logic                     sp_we;

    assign busy_o = (state != ST_IDLE);
    assign sp_we  = (state == ST_WRITE);

    matmul_result_sp #(
        .EL_W   (EL_W),
        .NUM_EL (NUM_EL),
        .NT     (SP_NTARGETS),
        .AW     (SP_AW),
        .IW     (IDX_W)
    ) u_sp (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .we       (sp_we),
        .waddr    (dst_q),
        .wdata    (cap_c),
        .baddr    (src_q),
        .bidx     (idx),
        .bdata    (bias_el),
        .rd_en    (rd_en_i),
        .raddr    (rd_addr_i[SP_AW+IDX_W-1:IDX_W]),
        .ridx     (rd_addr_i[IDX_W-1:0]),
        .rd_data  (rd_data_o),
        .rd_valid (rd_valid_o)
    );

    // Signed add of the current captured element and the bias element.
    // Overflow: operands share a sign that the sum does not.
    always_comb begin
        cur_el = cap_c[idx*EL_W +: EL_W];
        sum    = cur_el + bias_el;
        ovf    = (cur_el[EL_W-1] == bias_el[EL_W-1]) && (sum[EL_W-1] != cur_el[EL_W-1]);
`ifdef MATMUL_RESULT_SAT_EN
        if (ovf) begin
            sum_fix = cur_el[EL_W-1] ? {1'b1, {(EL_W-1){1'b0}}} : {1'b0, {(EL_W-1){1'b1}}};
        end else begin
            sum_fix = sum;
        end
`else
        sum_fix = sum;
`endif
    end

    // The detected edge is registered, so capture happens the cycle after
    // finish_mul_i is first sampled high; the array holds its result while
    // finish is asserted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= ST_IDLE;
            fin_prev  <= 1'b0;
            edge_q    <= 1'b0;
            cap_c     <= '0;
            cap_flags <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            idx       <= '0;
            flags_o   <= '0;
            done_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            fin_prev <= finish_mul_i;
            edge_q   <= finish_mul_i & ~fin_prev;
            done_o   <= 1'b0;

            if (edge_q && state != ST_IDLE) begin
                overrun_o <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (edge_q) begin
                        cap_c     <= c_matrix_i;
                        cap_flags <= flags_i;
                        src_q     <= src_sp_i;
                        dst_q     <= dst_sp_i;
                        idx       <= '0;
                        state     <= mode_bias_i ? ST_ADD : ST_WRITE;
                    end
                end
                ST_ADD: begin
                    // Bias comes from the array, which is untouched until WRITE,
                    // so src == dst reads the pre-op content.
                    cap_c[idx*EL_W +: EL_W] <= sum_fix;
                    cap_flags[idx]          <= cap_flags[idx] | ovf;
                    if (idx == IDX_W'(NUM_EL-1)) begin
                        state <= ST_WRITE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_WRITE: begin
                    flags_o <= cap_flags;
                    done_o  <= 1'b1;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_result_unit.sv
// Randomised scoreboard bench for matmul_result_unit (default parameters).
// Reads push their expected data into a queue; a monitor pops on rd_valid_o.
// Op results come from a plain-integer reference model of the scratchpad.
module tb_matmul_result_unit;
    import matmul_result_unit_pkg::*;

    localparam int NE = 4;
    localparam int EW = 16;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [NE*EW-1:0] c_matrix_i;
    logic [NE-1:0]   flags_i;
    logic            finish_mul_i;
    logic            mode_bias_i;
    logic [1:0]      src_sp_i;
    logic [1:0]      dst_sp_i;
    logic            rd_en_i;
    logic [3:0]      rd_addr_i;
    logic [EW-1:0]   rd_data_o;
    logic            rd_valid_o;
    logic [NE-1:0]   flags_o;
    logic            busy_o;
    logic            done_o;
    logic            overrun_o;

    always #5 clk = ~clk;

    matmul_result_unit dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .c_matrix_i   (c_matrix_i),
        .flags_i      (flags_i),
        .finish_mul_i (finish_mul_i),
        .mode_bias_i  (mode_bias_i),
        .src_sp_i     (src_sp_i),
        .dst_sp_i     (dst_sp_i),
        .rd_en_i      (rd_en_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .flags_o      (flags_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overrun_o    (overrun_o)
    );

    int            nvec = 0;
    int            nerr = 0;
    logic [EW-1:0] sp_model [4][NE];
    logic [EW-1:0] rdq [$];
    logic          exp_vld = 1'b0;
    logic          exp_ovr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Read response monitor
    always @(posedge clk) exp_vld <= rst_ni & rd_en_i;

    always @(negedge clk) begin
        chk("rd_valid", 32'(rd_valid_o), 32'(exp_vld));
        if (rd_valid_o) begin
            if (rdq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL rd_data: got %0h with no read outstanding", rd_data_o);
            end else begin
                chk("rd_data", 32'(rd_data_o), 32'(rdq.pop_front()));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference op: signed integer add with range check
    task automatic calc(input logic [NE-1:0][EW-1:0] cv, input logic [NE-1:0] fl, input logic bias,
                        input logic [1:0] src, output logic [NE-1:0][EW-1:0] res, output logic [NE-1:0] fo);
        int s;
        fo = fl;
        for (int e = 0; e < NE; e++) begin
            if (!bias) begin
                res[e] = cv[e];
            end else begin
                s = int'($signed(cv[e])) + int'($signed(sp_model[src][e]));
                if (s > 32767 || s < -32768) begin
                    fo[e] = 1'b1;
`ifdef MATMUL_RESULT_SAT_EN
                    res[e] = (s > 0) ? 16'h7FFF : 16'h8000;
`else
                    res[e] = 16'(s);
`endif
                end else begin
                    res[e] = 16'(s);
                end
            end
        end
    endtask

    task automatic read_entry(input logic [1:0] e);
        for (int k = 0; k < NE; k++) begin
            @(negedge clk);
            rd_en_i   = 1'b1;
            rd_addr_i = {e, 2'(k)};
            rdq.push_back(sp_model[e][k]);
        end
        @(negedge clk);
        rd_en_i = 1'b0;
    endtask

    // One completion: finish held high 5 cycles. ovr injects a second edge
    // during ADD with different inputs; rdw reads dst element 0 in the WRITE
    // cycle and the cycle after.
    task automatic run_op(input logic [NE-1:0][EW-1:0] cv, input logic [NE-1:0] fl, input logic bias,
                          input logic [1:0] src, input logic [1:0] dst, input logic ovr, input logic rdw);
        logic [NE-1:0][EW-1:0] res;
        logic [NE-1:0]         fo;
        int ndone, lat, exp_lat;
        calc(cv, fl, bias, src, res, fo);
        exp_lat = bias ? 3 + NE : 3;
        ndone = 0;
        lat = 0;
        @(negedge clk);
        c_matrix_i   = cv;
        flags_i      = fl;
        mode_bias_i  = bias;
        src_sp_i     = src;
        dst_sp_i     = dst;
        finish_mul_i = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (done_o) begin
                ndone++;
                if (lat == 0) lat = i;
            end
            if (i == 2) chk("busy_high", 32'(busy_o), 32'd1);
            if (i == exp_lat + 1) chk("busy_low", 32'(busy_o), 32'd0);
            if (ovr) begin
                if (i == 2) finish_mul_i = 1'b0;
                if (i == 3) begin
                    finish_mul_i = 1'b1;
                    c_matrix_i   = ~cv;
                    flags_i      = ~fl;
                    mode_bias_i  = 1'b0;
                    dst_sp_i     = ~dst;
                end
            end
            if (i == 5) finish_mul_i = 1'b0;
            if (rdw) begin
                if (i == exp_lat - 1) begin
                    rd_en_i   = 1'b1;
                    rd_addr_i = {dst, 2'd0};
                    rdq.push_back(sp_model[dst][0]);
                end
                if (i == exp_lat) rdq.push_back(res[0]);
                if (i == exp_lat + 1) rd_en_i = 1'b0;
            end
        end
        chk("done_count", 32'(ndone), 32'd1);
        chk("done_latency", 32'(lat), 32'(exp_lat));
        chk("flags_o", 32'(flags_o), 32'(fo));
        if (ovr) exp_ovr = 1'b1;
        chk("overrun", 32'(overrun_o), 32'(exp_ovr));
        for (int e = 0; e < NE; e++) sp_model[dst][e] = res[e];
    endtask

    initial begin
        logic [NE-1:0][EW-1:0] cv;
        int ndone;

        rst_ni       = 1'b0;
        c_matrix_i   = '0;
        flags_i      = '0;
        finish_mul_i = 1'b0;
        mode_bias_i  = 1'b0;
        src_sp_i     = '0;
        dst_sp_i     = '0;
        rd_en_i      = 1'b0;
        rd_addr_i    = '0;
        for (int t = 0; t < 4; t++) for (int e = 0; e < NE; e++) sp_model[t][e] = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        chk("rst_flags", 32'(flags_o), 32'd0);
        chk("rst_rd_data", 32'(rd_data_o), 32'd0);
        rst_ni = 1'b1;
        read_entry(2'd1);

        // Plain write, no bias
        cv = {16'd4, 16'd3, 16'd2, 16'd1};
        run_op(cv, 4'b0000, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
        read_entry(2'd2);

        // Bias from entry 1 into entry 3
        cv = {16'd7, 16'd0, 16'hFFFB, 16'd10};
        run_op(cv, 4'b0000, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0);
        cv = {16'd1, 16'd1, 16'd1, 16'd1};
        run_op(cv, 4'b0000, 1'b1, 2'd1, 2'd3, 1'b0, 1'b0);
        read_entry(2'd3);

        // Overflow both directions, PE flag passthrough, src == dst
        cv = {16'd0, 16'd5, 16'h8000, 16'h7FFF};
        run_op(cv, 4'b0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        cv = {16'd0, 16'd3, 16'hFFFF, 16'h0001};
        run_op(cv, 4'b1000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0);
        read_entry(2'd0);

        // Read of dst in the write cycle sees old data, next cycle new data
        cv = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
        run_op(cv, 4'b0101, 1'b0, 2'd0, 2'd2, 1'b0, 1'b1);
        cv = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_op(cv, 4'b0000, 1'b1, 2'd2, 2'd2, 1'b0, 1'b1);

        // Second edge during ADD: ignored, overrun sticky
        cv = {16'd100, 16'd200, 16'd300, 16'd400};
        run_op(cv, 4'b0010, 1'b1, 2'd3, 2'd1, 1'b1, 1'b0);
        read_entry(2'd1);
        read_entry(2'd2);

        // Random ops
        for (int n = 0; n < 30; n++) begin
            for (int e = 0; e < NE; e++) cv[e] = 16'($urandom);
            run_op(cv, 4'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 1'b0, 1'($urandom));
            read_entry(2'($urandom));
        end

        // Reset in the middle of ADD discards the op and clears everything
        @(negedge clk);
        c_matrix_i   = {16'd9, 16'd9, 16'd9, 16'd9};
        mode_bias_i  = 1'b1;
        src_sp_i     = 2'd0;
        dst_sp_i     = 2'd1;
        finish_mul_i = 1'b1;
        repeat (3) @(negedge clk);
        finish_mul_i = 1'b0;
        rst_ni       = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_overrun", 32'(overrun_o), 32'd0);
        chk("reset_flags", 32'(flags_o), 32'd0);
        exp_ovr = 1'b0;
        for (int t = 0; t < 4; t++) for (int e = 0; e < NE; e++) sp_model[t][e] = '0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        chk("reset_no_done", 32'(ndone), 32'd0);
        for (int t = 0; t < 4; t++) read_entry(2'(t));

        // Fresh op after reset
        cv = {16'd8, 16'd6, 16'd4, 16'd2};
        run_op(cv, 4'b0001, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0);
        read_entry(2'd1);

        repeat (4) @(negedge clk);
        chk("reads_pending", 32'(rdq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
